// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline control path.
// BUBBLE_INST is the instruction word the stage registers load on a flush.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      S_INIT    = 2'd0,
      S_RUN     = 2'd1,
      S_MEMWAIT = 2'd2,
      S_ERR     = 2'd3
   } state_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam logic [31:0] BUBBLE_INST = 32'h0000_0033;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects for rs1 and rs2.
// The younger EX/MEM result wins over the MEM/WB result.
module fwd_unit
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs1_addr,
   input  logic [4:0] ex_rs2_addr,
   input  logic [4:0] mem_rd_addr,
   input  logic       mem_regwrite,
   input  logic [4:0] wb_rd_addr,
   input  logic       wb_regwrite,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   logic [4:0] src_addr [2];
   logic [1:0] sel      [2];

   assign src_addr[0] = ex_rs1_addr;
   assign src_addr[1] = ex_rs2_addr;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         always_comb begin
            sel[gi] = FWD_RF;
            if (mem_regwrite && (mem_rd_addr != 5'd0) && (mem_rd_addr == src_addr[gi]))
               sel[gi] = FWD_EXMEM;
            else if (wb_regwrite && (wb_rd_addr != 5'd0) && (wb_rd_addr == src_addr[gi]))
               sel[gi] = FWD_MEMWB;
         end
      end
   endgenerate

   assign fwd_a = sel[0];
   assign fwd_b = sel[1];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: warm-up, load-use stalls, redirects,
// data-memory waits with timeout, forwarding selects and perf counters.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int INIT_CYCLES = 4,
   parameter int TIMEOUT     = 255,
   parameter int CNT_W       = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic [4:0]       ex_rs1_addr,
   input  logic [4:0]       ex_rs2_addr,
   input  logic             ex_redirect,
   input  logic [4:0]       mem_rd_addr,
   input  logic             mem_regwrite,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic [4:0]       wb_rd_addr,
   input  logic             wb_regwrite,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

   state_t            state_reg, state_next;
   logic [INIT_W-1:0] init_cnt_reg, init_cnt_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic              stall_inc, flush_inc, load_use;

   assign load_use = ex_memread && ex_regwrite && (ex_rd_addr != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                      (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

   always_comb begin
      state_next    = state_reg;
      init_cnt_next = init_cnt_reg;
      wait_cnt_next = wait_cnt_reg;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      idex_en       = 1'b1;
      exmem_en      = 1'b1;
      memwb_en      = 1'b1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      exmem_flush   = 1'b0;
      memwb_flush   = 1'b0;

      case (state_reg)
         S_INIT: begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
            if (init_cnt_reg == INIT_LAST)
               state_next = S_RUN;
            else
               init_cnt_next = init_cnt_reg + 1'b1;
         end
         S_RUN, S_MEMWAIT: begin
            // An outstanding wait keeps the pipe frozen whatever mem_req does now.
            if (!mem_ready && (mem_req || (state_reg == S_MEMWAIT))) begin
               {pc_en, ifid_en, idex_en, exmem_en} = '0;
               memwb_flush   = 1'b1;
               stall_inc     = 1'b1;
               wait_cnt_next = wait_cnt_reg + 1'b1;
               state_next    = (wait_cnt_next >= WAIT_MAX) ? S_ERR : S_MEMWAIT;
            end else begin
               state_next    = S_RUN;
               wait_cnt_next = '0;
               if (ex_redirect) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  flush_inc  = 1'b1;
               end else if (load_use) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
                  stall_inc  = 1'b1;
               end
            end
         end
         default: begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            memwb_flush = 1'b1;
         end
      endcase

      if (rst) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
         {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_INIT;
         init_cnt_reg <= '0;
         wait_cnt_reg <= '0;
         stall_cnt    <= '0;
         flush_cnt    <= '0;
         mem_timeout  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         init_cnt_reg <= init_cnt_next;
         wait_cnt_reg <= wait_cnt_next;
         if (stall_inc)
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc)
            flush_cnt <= flush_cnt + 1'b1;
         if (state_next == S_ERR)
            mem_timeout <= 1'b1;
      end
   end

   fwd_unit u_fwd (
      .ex_rs1_addr  (ex_rs1_addr),
      .ex_rs2_addr  (ex_rs2_addr),
      .mem_rd_addr  (mem_rd_addr),
      .mem_regwrite (mem_regwrite),
      .wb_rd_addr   (wb_rd_addr),
      .wb_regwrite  (wb_regwrite),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random stimulus for pipeline_hazard_ctrl, checked against a
// behavioural model tracking warm-up cycles left, wait length and error flag.
module tb_pipeline_hazard_ctrl;

   localparam int INIT_CYCLES = 4;
   localparam int TIMEOUT     = 8;
   localparam int CNT_W       = 32;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
   logic [4:0] mem_rd_addr, wb_rd_addr;
   logic id_uses_rs1, id_uses_rs2, ex_memread, ex_regwrite, ex_redirect;
   logic mem_regwrite, mem_req, mem_ready, wb_regwrite;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic [1:0] fwd_a, fwd_b;
   logic mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .INIT_CYCLES (INIT_CYCLES),
      .TIMEOUT     (TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs1_addr  (id_rs1_addr),
      .id_rs2_addr  (id_rs2_addr),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .ex_rd_addr   (ex_rd_addr),
      .ex_memread   (ex_memread),
      .ex_regwrite  (ex_regwrite),
      .ex_rs1_addr  (ex_rs1_addr),
      .ex_rs2_addr  (ex_rs2_addr),
      .ex_redirect  (ex_redirect),
      .mem_rd_addr  (mem_rd_addr),
      .mem_regwrite (mem_regwrite),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .wb_rd_addr   (wb_rd_addr),
      .wb_regwrite  (wb_regwrite),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_en      (idex_en),
      .exmem_en     (exmem_en),
      .memwb_en     (memwb_en),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .exmem_flush  (exmem_flush),
      .memwb_flush  (memwb_flush),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .mem_timeout  (mem_timeout),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   int          passed = 0;
   int          total  = 0;
   int          failed = 0;
   int          init_left = INIT_CYCLES;
   int          wait_run  = 0;
   bit          err       = 1'b0;
   int unsigned m_stall   = 0;
   int unsigned m_flush   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] fwd_model(input logic [4:0] rs);
      if (mem_regwrite && mem_rd_addr != 0 && mem_rd_addr == rs) return 2'd1;
      if (wb_regwrite && wb_rd_addr != 0 && wb_rd_addr == rs) return 2'd2;
      return 2'd0;
   endfunction

   task automatic idle();
      {id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_rs1_addr, ex_rs2_addr} = '0;
      {mem_rd_addr, wb_rd_addr} = '0;
      {id_uses_rs1, id_uses_rs2, ex_memread, ex_regwrite, ex_redirect} = '0;
      {mem_regwrite, mem_req, mem_ready, wb_regwrite} = '0;
   endtask

   // One clock cycle: check outputs at the negedge, advance the model, then the DUT edge.
   task automatic step(input string what);
      logic [4:0] e_en;
      logic [3:0] e_fl;
      bit lu, freeze;
      @(negedge clk);
      if (rst) begin
         init_left = INIT_CYCLES; wait_run = 0; err = 1'b0; m_stall = 0; m_flush = 0;
      end
      lu = ex_memread && ex_regwrite && ex_rd_addr != 0 &&
           ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
      freeze = 1'b0;
      if (rst || init_left > 0) begin
         e_en = 5'b00000; e_fl = 4'b1111;
      end else if (err) begin
         e_en = 5'b00000; e_fl = 4'b0001;
      end else if (!mem_ready && (mem_req || wait_run > 0)) begin
         freeze = 1'b1; e_en = 5'b00001; e_fl = 4'b0001;
      end else if (ex_redirect) begin
         e_en = 5'b11111; e_fl = 4'b1100;
      end else if (lu) begin
         e_en = 5'b00111; e_fl = 4'b0100;
      end else begin
         e_en = 5'b11111; e_fl = 4'b0000;
      end
      check({what, ":enables"}, {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e_en);
      check({what, ":flushes"}, {ifid_flush, idex_flush, exmem_flush, memwb_flush}, e_fl);
      check({what, ":fwd_a"}, fwd_a, fwd_model(ex_rs1_addr));
      check({what, ":fwd_b"}, fwd_b, fwd_model(ex_rs2_addr));
      check({what, ":mem_timeout"}, mem_timeout, err);
      check({what, ":stall_cnt"}, stall_cnt, m_stall);
      check({what, ":flush_cnt"}, flush_cnt, m_flush);
      $display("step %-8s en=%b fl=%b fa=%0d fb=%0d to=%0b stall=%0d flush=%0d",
               what, {pc_en, ifid_en, idex_en, exmem_en, memwb_en},
               {ifid_flush, idex_flush, exmem_flush, memwb_flush},
               fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt);
      if (!rst) begin
         if (init_left > 0) init_left--;
         else if (!err) begin
            if (freeze) begin
               m_stall++; wait_run++;
               if (wait_run >= TIMEOUT) err = 1'b1;
            end else begin
               wait_run = 0;
               if (ex_redirect) m_flush++;
               else if (lu) m_stall++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use(input logic [4:0] rd);
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd_addr = rd;
      id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      step("reset");
      step("reset");
      rst = 1'b0;
      repeat (INIT_CYCLES) step("init");
      check("warmup_pc_en", pc_en, 1'b1);

      set_load_use(5'd5);
      step("ld_use");
      idle();
      step("idle");
      check("ld_use_stall", stall_cnt, 1);
      set_load_use(5'd0);
      step("ld_x0");
      idle();
      step("idle");
      check("ld_x0_stall", stall_cnt, 1);

      set_load_use(5'd5);
      ex_redirect = 1'b1;
      step("redir");
      idle();
      step("idle");
      check("redir_flush", flush_cnt, 1);
      check("redir_stall", stall_cnt, 1);

      mem_req = 1'b1; mem_ready = 1'b0;
      repeat (3) step("memwait");
      mem_ready = 1'b1;
      step("release");
      idle();
      step("idle");
      check("memwait_stall", stall_cnt, 4);

      mem_rd_addr = 5'd7; wb_rd_addr = 5'd7; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
      ex_rs1_addr = 5'd7; ex_rs2_addr = 5'd7;
      step("fwd_ex");
      check("fwd_exmem", {fwd_a, fwd_b}, 4'b0101);
      mem_regwrite = 1'b0;
      step("fwd_wb");
      check("fwd_memwb", {fwd_a, fwd_b}, 4'b1010);
      mem_rd_addr = 5'd0; wb_rd_addr = 5'd0; mem_regwrite = 1'b1;
      step("fwd_x0");
      check("fwd_rf", {fwd_a, fwd_b}, 4'b0000);

      for (int i = 0; i < 300; i++) begin
         id_rs1_addr  = 5'($urandom_range(0, 3));
         id_rs2_addr  = 5'($urandom_range(0, 3));
         id_uses_rs1  = 1'($urandom);
         id_uses_rs2  = 1'($urandom);
         ex_rd_addr   = 5'($urandom_range(0, 3));
         ex_memread   = 1'($urandom);
         ex_regwrite  = 1'($urandom_range(0, 3) != 0);
         ex_rs1_addr  = 5'($urandom_range(0, 3));
         ex_rs2_addr  = 5'($urandom_range(0, 3));
         ex_redirect  = ($urandom_range(0, 5) == 0);
         mem_rd_addr  = 5'($urandom_range(0, 3));
         mem_regwrite = 1'($urandom);
         mem_req      = ($urandom_range(0, 3) == 0);
         mem_ready    = ($urandom_range(0, 2) != 0);
         wb_rd_addr   = 5'($urandom_range(0, 3));
         wb_regwrite  = 1'($urandom);
         step("random");
      end

      rst = 1'b1;
      idle();
      step("reset");
      rst = 1'b0;
      repeat (INIT_CYCLES) step("init");
      mem_req = 1'b1; mem_ready = 1'b0;
      repeat (TIMEOUT - 1) step("wait");
      check("timeout_early", mem_timeout, 1'b0);
      step("wait");
      check("timeout_set", mem_timeout, 1'b1);
      mem_ready = 1'b1;
      ex_redirect = 1'b1;
      repeat (3) step("err");
      check("timeout_sticky", mem_timeout, 1'b1);
      rst = 1'b1;
      idle();
      step("reset");
      check("timeout_clear", mem_timeout, 1'b0);
      rst = 1'b0;
      step("init");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
